// File: rtl/keccak_pkg.sv
// Shared Keccak constants and the permute controller state encoding.
package keccak_pkg;
   localparam int KECCAK_ROUNDS = 24;

   typedef enum logic [2:0] {
      IDLE,
      PERMUTE,
      WAIT_IN,
      SQUEEZE,
      DONE
   } permute_ctrl_state_t;
endpackage

// File: rtl/permute_controller_if.sv
// Block handshake between the permute controller and its input/output buffer stages.
interface permute_controller_if;
   logic in_valid;
   logic in_last;
   logic in_ready;
   logic out_ready;
   logic out_valid;

   modport master (
      input  in_valid,
      input  in_last,
      input  out_ready,
      output in_ready,
      output out_valid
   );

   modport slave (
      output in_valid,
      output in_last,
      output out_ready,
      input  in_ready,
      input  out_valid
   );
endinterface

// File: rtl/countern.sv
// Up-counter with synchronous clear that wraps to zero after MAX.
module countern #(
   parameter int WIDTH = 5,
   parameter int MAX   = (1 << WIDTH) - 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count
);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en)
         count <= (count == MAX_V) ? '0 : count + ONE;
   end
endmodule

// File: rtl/permute_controller.sv
// Sequences absorb / 24-round permutation / squeeze for one SHAKE message and
// cross-checks the datapath round counter against its own round count.
module permute_controller
   import keccak_pkg::*;
#(
   parameter int ROUNDS = KECCAK_ROUNDS
) (
   input  logic                 clk,
   input  logic                 rst,
   permute_controller_if.master bus,
   output logic                 copy_control_data,
   output logic                 absorb_enable,
   output logic                 round_en,
   output logic                 round_count_load,
   output logic                 output_size_count_en,
   output logic                 state_reset,
   input  logic                 round_start,
   input  logic                 round_done,
   input  logic                 last_output_block,
   output logic                 busy,
   output logic                 msg_done,
   output logic                 error
);
   localparam int              CW       = $clog2(ROUNDS);
   localparam logic [CW-1:0]   LAST_RND = CW'(ROUNDS - 1);

   permute_ctrl_state_t state_reg, state_next;
   logic                last_blk_reg;
   logic                error_reg;
   logic [CW-1:0]       rnd_cnt;
   logic                in_ready;
   logic                out_valid;

   // Every round_en advances the count; it wraps to 0 on the final round,
   // which leaves it at 0 whenever the FSM is outside PERMUTE.
   countern #(.WIDTH(CW), .MAX(ROUNDS - 1)) u_rnd_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (state_reset),
      .en    (round_en),
      .count (rnd_cnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         last_blk_reg <= 1'b0;
         error_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (in_ready)
            last_blk_reg <= bus.in_last;
         if (round_en && ((round_start && (rnd_cnt != '0)) ||
                          (round_done != (rnd_cnt == LAST_RND))))
            error_reg <= 1'b1;
      end
   end

   always_comb begin
      state_next           = state_reg;
      in_ready             = 1'b0;
      out_valid            = 1'b0;
      copy_control_data    = 1'b0;
      absorb_enable        = 1'b0;
      round_en             = 1'b0;
      round_count_load     = 1'b0;
      output_size_count_en = 1'b0;
      state_reset          = 1'b0;
      msg_done             = 1'b0;
      case (state_reg)
         IDLE: begin
            state_reset      = !bus.in_valid;
            round_count_load = !bus.in_valid;
            if (bus.in_valid) begin
               in_ready          = 1'b1;
               copy_control_data = 1'b1;
               absorb_enable     = 1'b1;
               round_en          = 1'b1;
               state_next        = PERMUTE;
            end
         end
         PERMUTE: begin
            round_en = 1'b1;
            if (rnd_cnt == LAST_RND)
               state_next = last_blk_reg ? SQUEEZE : WAIT_IN;
         end
         WAIT_IN: begin
            if (bus.in_valid) begin
               in_ready      = 1'b1;
               absorb_enable = 1'b1;
               round_en      = 1'b1;
               state_next    = PERMUTE;
            end
         end
         SQUEEZE: begin
            if (bus.out_ready) begin
               out_valid            = 1'b1;
               output_size_count_en = 1'b1;
               if (last_output_block) begin
                  state_next = DONE;
               end else begin
                  round_en   = 1'b1;
                  state_next = PERMUTE;
               end
            end
         end
         DONE: begin
            msg_done         = 1'b1;
            state_reset      = 1'b1;
            round_count_load = 1'b1;
            state_next       = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign busy          = (state_reg != IDLE);
   assign error         = error_reg;
endmodule

// File: tb/tb_permute_controller.sv
// Directed + randomized bench: expected strobe timing comes from a per-message
// schedule of pop, squeeze and round intervals computed with plain arithmetic.
module tb_permute_controller;
   import keccak_pkg::*;

   localparam int R = 24;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   permute_controller_if bus();

   logic copy_control_data, absorb_enable, round_en, round_count_load;
   logic output_size_count_en, state_reset, round_start, round_done;
   logic last_output_block, busy, msg_done, error;

   permute_controller #(.ROUNDS(R)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .bus                  (bus),
      .copy_control_data    (copy_control_data),
      .absorb_enable        (absorb_enable),
      .round_en             (round_en),
      .round_count_load     (round_count_load),
      .output_size_count_en (output_size_count_en),
      .state_reset          (state_reset),
      .round_start          (round_start),
      .round_done           (round_done),
      .last_output_block    (last_output_block),
      .busy                 (busy),
      .msg_done             (msg_done),
      .error                (error)
   );

   int checks = 0;
   int fails  = 0;
   bit err_exp = 1'b0;

   task automatic chk(input string tag, input logic obs, input logic exp_v);
      checks++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
      end
   endtask

   // Runs one message. Cycle 0 is the first in_valid cycle with the DUT idle.
   task automatic run_msg(input int id, input int nblk, input int nout,
                          input int wait_gap, input bit inject);
      int avail[8], pop[8], sq[8], rdy[8], outc[8], starts[16];
      int ns, done, inj_cyc, idx, cur, kin;
      bit iv, is_pop, is_out, idle_e;
      avail[0] = 0;
      pop[0]   = 0;
      for (int k = 1; k < nblk; k++) begin
         if (wait_gap > 0)
            avail[k] = pop[k-1] + R + wait_gap;
         else
            avail[k] = pop[k-1] + 1 + int'($urandom_range(0, 35));
         pop[k] = (avail[k] > pop[k-1] + R) ? avail[k] : pop[k-1] + R;
      end
      sq[0] = pop[nblk-1] + R;
      for (int j = 0; j < nout; j++) begin
         rdy[j]  = sq[j] + int'($urandom_range(0, 6));
         outc[j] = rdy[j];
         if (j < nout - 1)
            sq[j+1] = outc[j] + R;
      end
      done = outc[nout-1] + 1;
      ns = 0;
      for (int k = 0; k < nblk; k++) begin starts[ns] = pop[k]; ns++; end
      for (int j = 0; j < nout - 1; j++) begin starts[ns] = outc[j]; ns++; end
      inj_cyc = inject ? pop[0] + R - 2 : -10;

      for (int c = 0; c <= done + 1; c++) begin
         @(negedge clk);
         iv = 1'b0; kin = 0; is_pop = 1'b0; is_out = 1'b0;
         for (int k = 0; k < nblk; k++) begin
            if (c >= avail[k] && c <= pop[k]) begin iv = 1'b1; kin = k; end
            if (c == pop[k]) is_pop = 1'b1;
         end
         cur = nout;
         for (int j = nout - 1; j >= 0; j--) begin
            if (c <= outc[j]) cur = j;
            if (c == outc[j]) is_out = 1'b1;
         end
         if (c == done) iv = 1'b1;
         bus.in_valid = iv;
         bus.in_last  = (iv && c != done) ? (kin == nblk - 1) : 1'($urandom);
         if (cur < nout) begin
            bus.out_ready = (c >= rdy[cur]) || (c < sq[cur] && 1'($urandom));
            last_output_block = (c >= sq[cur]) ? (cur == nout - 1) : 1'($urandom);
         end else begin
            bus.out_ready     = 1'($urandom);
            last_output_block = 1'($urandom);
         end
         idx = -1;
         for (int s = 0; s < ns; s++)
            if (c >= starts[s] && c < starts[s] + R) idx = c - starts[s];
         round_start = (idx == 0);
         if (inject && c == inj_cyc)
            round_done = 1'b1;
         else if (inject && c == inj_cyc + 1)
            round_done = 1'b0;
         else
            round_done = (idx == R - 1);
         idle_e = (c == 0) || (c == done + 1);
         #1;
         chk("in_ready", bus.in_ready, is_pop && c != done);
         chk("absorb_enable", absorb_enable, is_pop && c != done);
         chk("copy_control_data", copy_control_data, c == 0);
         chk("round_en", round_en, idx >= 0);
         chk("out_valid", bus.out_valid, is_out);
         chk("output_size_count_en", output_size_count_en, is_out);
         chk("msg_done", msg_done, c == done);
         chk("busy", busy, !idle_e);
         chk("state_reset", state_reset, (idle_e && !iv) || c == done);
         chk("round_count_load", round_count_load, (idle_e && !iv) || c == done);
         chk("error", error, err_exp);
         if (inject && c == inj_cyc) err_exp = 1'b1;
      end
      $display("msg %0d: blocks=%0d outputs=%0d last_pop=T%0d first_out=T%0d done=T%0d inject=%0d",
               id, nblk, nout, pop[nblk-1], outc[0], done, inject);
   endtask

   initial begin
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
      round_start = 1'b0; round_done = 1'b0; last_output_block = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_state_reset", state_reset, 1'b1);
      chk("rst_round_count_load", round_count_load, 1'b1);
      chk("rst_round_en", round_en, 1'b0);
      chk("rst_in_ready", bus.in_ready, 1'b0);
      chk("rst_error", error, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      run_msg(1, 1, 1, 0, 1'b0);
      run_msg(2, 3, 1, 0, 1'b0);
      run_msg(3, 1, 3, 0, 1'b0);
      run_msg(4, 2, 1, 10, 1'b0);

      // Reset in the middle of a permutation.
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_last = 1'b1; round_start = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0; round_start = 1'b0;
      repeat (9) @(negedge clk);
      #1;
      chk("mid_round_en_before_rst", round_en, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_round_en", round_en, 1'b0);
      chk("mid_rst_state_reset", state_reset, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      $display("reset mid-permute applied");

      run_msg(5, 1, 2, 0, 1'b1);
      @(negedge clk);
      #1;
      chk("error_sticky_idle", error, 1'b1);
      rst = 1'b1;
      #1;
      chk("error_cleared_by_rst", error, 1'b0);
      err_exp = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++)
         run_msg(6 + i, int'($urandom_range(1, 4)), int'($urandom_range(1, 3)), 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish within the time limit");
      $fatal(1, "timeout");
   end
endmodule
